// File: rtl/act_pkg.sv
// Shared definitions for the activation-stage requantizers.
// Q3.5 is a signed 8-bit format: 3 integer bits (sign included) and 5
// fractional bits, so it spans -4.0 to +3.96875.
// Ports: none (package only).
package act_pkg;

  typedef logic signed [7:0] q35_t;

  localparam int unsigned Q35_FRAC = 5;
  localparam q35_t        Q35_MIN  = q35_t'(-128);
  localparam q35_t        Q35_MAX  = q35_t'(127);

endpackage

// File: rtl/round_shift_sat.sv
// Combinational round / arithmetic shift / saturate helper for activation
// requantizers. The rounding path and the saturation path are independent,
// which lets the caller put a pipeline register between them.
// Ports:
//   i_val   signed product to requantize
//   i_shift right-shift amount
//   o_rnd   round-half-up (toward +inf) shifted value, one bit wider than i_val
//   i_rnd   a previously rounded value to clip into Q3.5
//   o_q     clipped Q3.5 result
//   o_sat   i_rnd was outside the Q3.5 range
module round_shift_sat
  import act_pkg::*;
#(
  parameter int unsigned IN_W    = 32,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic signed [IN_W-1:0]    i_val,
  input  logic        [SHIFT_W-1:0] i_shift,
  output logic signed [IN_W:0]      o_rnd,
  input  logic signed [IN_W:0]      i_rnd,
  output q35_t                      o_q,
  output logic                      o_sat
);

  localparam logic signed [IN_W:0]    RND_ONE = (IN_W+1)'(1);
  localparam logic        [SHIFT_W-1:0] SH_ONE  = SHIFT_W'(1);

  logic signed [IN_W:0] w_ext;
  logic signed [IN_W:0] w_half;
  logic signed [IN_W:0] w_sum;
  logic [IN_W-7:0]      w_top;

  // One extra bit of headroom so adding the half-LSB never overflows.
  always_comb begin
    w_ext  = {i_val[IN_W-1], i_val};
    w_half = '0;
    w_sum  = w_ext;
    o_rnd  = w_ext;
    if (i_shift != '0) begin
      w_half = RND_ONE <<< (i_shift - SH_ONE);
      w_sum  = w_ext + w_half;
      o_rnd  = w_sum >>> i_shift;
    end
  end

  // In range exactly when every bit from 7 upward equals the sign bit.
  always_comb begin
    w_top = i_rnd[IN_W:7];
    o_sat = ~((&w_top) | ~(|w_top));
    if (o_sat) begin
      o_q = i_rnd[IN_W] ? Q35_MIN : Q35_MAX;
    end else begin
      o_q = q35_t'(i_rnd[7:0]);
    end
  end

endmodule

// File: rtl/acc_requant_q35.sv
// Requantizes signed MAC accumulator values into Q3.5 samples for the tanh
// stage: S1 multiplies by an unsigned scale, S2 rounds and shifts, S3 clips.
// The whole pipeline advances together when the output is empty or taken.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   acc_in, mult_in, shift_in  sample, scale and right-shift, captured together
//   out_valid / out_ready output handshake
//   q_out, sat_out        Q3.5 result and its clip flag
//   sat_count             clipped outputs since reset, sticks at all-ones
module acc_requant_q35
  import act_pkg::*;
#(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned MULT_W  = 8,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [MULT_W-1:0]  mult_in,
  input  logic [SHIFT_W-1:0] shift_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         q_out,
  output logic               sat_out,
  output logic [CNT_W-1:0]   sat_count
);

  localparam int unsigned PROD_W = ACC_W + MULT_W;

  logic                      w_advance;
  logic signed [PROD_W-1:0]  w_acc_ext;
  logic signed [PROD_W-1:0]  w_mult_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W:0]    w_rnd;
  q35_t                      w_q;
  logic                      w_sat;

  logic                      r_s1_valid;
  logic signed [PROD_W-1:0]  r_s1_prod;
  logic [SHIFT_W-1:0]        r_s1_shift;
  logic                      r_s2_valid;
  logic signed [PROD_W:0]    r_s2_rnd;
  logic                      r_s3_valid;
  q35_t                      r_q;
  logic                      r_sat;
  logic [CNT_W-1:0]          r_cnt;

  assign w_advance = ~r_s3_valid | out_ready;
  assign in_ready  = w_advance & ~reset;

  // Both operands widened to the product width; the scale is zero-extended.
  assign w_acc_ext  = $signed({{MULT_W{acc_in[ACC_W-1]}}, acc_in});
  assign w_mult_ext = $signed({{ACC_W{1'b0}}, mult_in});
  assign w_prod     = w_acc_ext * w_mult_ext;

  round_shift_sat #(
    .IN_W    (PROD_W),
    .SHIFT_W (SHIFT_W)
  ) u_rss (
    .i_val   (r_s1_prod),
    .i_shift (r_s1_shift),
    .o_rnd   (w_rnd),
    .i_rnd   (r_s2_rnd),
    .o_q     (w_q),
    .o_sat   (w_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_prod  <= '0;
      r_s1_shift <= '0;
      r_s2_valid <= 1'b0;
      r_s2_rnd   <= '0;
      r_s3_valid <= 1'b0;
      r_q        <= '0;
      r_sat      <= 1'b0;
      r_cnt      <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_prod  <= w_prod;
      r_s1_shift <= shift_in;
      r_s2_valid <= r_s1_valid;
      r_s2_rnd   <= w_rnd;
      r_s3_valid <= r_s2_valid;
      r_q        <= w_q;
      r_sat      <= w_sat & r_s2_valid;
      if (r_s2_valid && w_sat && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_s3_valid;
  assign q_out     = r_q;
  assign sat_out   = r_sat;
  assign sat_count = r_cnt;

endmodule

// File: tb/tb_acc_requant_q35.sv
module tb_acc_requant_q35;

  localparam int unsigned ACC_W   = 24;
  localparam int unsigned MULT_W  = 8;
  localparam int unsigned SHIFT_W = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [ACC_W-1:0]   acc_in;
  logic [MULT_W-1:0]  mult_in;
  logic [SHIFT_W-1:0] shift_in;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         q_out;
  logic               sat_out;
  logic [15:0]        sat_count;

  logic               in_ready2;
  logic               out_valid2;
  logic [7:0]         q_out2;
  logic               sat_out2;
  logic [1:0]         sat_count2;

  acc_requant_q35 u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_in    (acc_in),
    .mult_in   (mult_in),
    .shift_in  (shift_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out),
    .sat_out   (sat_out),
    .sat_count (sat_count)
  );

  // Same stimulus, narrow counter to exercise counter saturation.
  acc_requant_q35 #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .acc_in    (acc_in),
    .mult_in   (mult_in),
    .shift_in  (shift_in),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .q_out     (q_out2),
    .sat_out   (sat_out2),
    .sat_count (sat_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int mult;
    int shift;
    int q;
    bit sat;
  } vec_t;

  typedef struct {
    int q;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_out   = 0;
  int   cyc     = 0;
  bit   use_tab = 1'b0;
  int   tab_q   = 0;
  bit   tab_sat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint act, longint req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endfunction

  // Reference: floor((2p + d) / 2d) with d = 2^shift, i.e. round half up.
  function automatic exp_t model(int acc, int mult, int sh);
    longint p, d, num, den, r;
    exp_t   e;
    p = longint'(acc) * longint'(mult);
    if (sh == 0) begin
      r = p;
    end else begin
      d   = longint'(1) << sh;
      num = 2 * p + d;
      den = 2 * d;
      r   = num / den;
      if ((num % den != 0) && (num < 0)) r = r - 1;
    end
    if (r > 127)       e = '{127, 1'b1};
    else if (r < -128) e = '{-128, 1'b1};
    else               e = '{int'(r), 1'b0};
    return e;
  endfunction

  // Scoreboard: push on input transfer, pop/compare on output transfer.
  logic [7:0] prev_q;
  logic       prev_sat;
  bit         prev_stall = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        if (use_tab) e = '{tab_q, tab_sat};
        else e = model(int'($signed(acc_in)), int'(mult_in), int'(shift_in));
        sb.push_back(e);
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", in_ready, 0);
        if (prev_stall) begin
          check("stall_q_hold", q_out, prev_q);
          check("stall_sat_hold", sat_out, prev_sat);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_q     = q_out;
      prev_sat   = sat_out;
      if (out_valid && out_ready) begin
        n_out++;
        check("output_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("q_out", longint'($signed(q_out)), e.q);
          check("sat_out", sat_out, e.sat);
        end
      end
    end
  end

  task automatic send(input int acc, input int mult, input int sh);
    int t;
    t        = 0;
    acc_in   = ACC_W'(acc);
    mult_in  = MULT_W'(mult);
    shift_in = SHIFT_W'(sh);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) check("send_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after an accept edge; returns edges until out_valid.
  task automatic latency(output int k);
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[11];
    vec_t clips[3];
    int   k, o0, c0, a, m, s;

    tab[0]  = '{64, 128, 8, 32, 1'b0};
    tab[1]  = '{3, 1, 1, 2, 1'b0};
    tab[2]  = '{-3, 1, 1, -1, 1'b0};
    tab[3]  = '{5, 3, 2, 4, 1'b0};
    tab[4]  = '{10000, 1, 0, 127, 1'b1};
    tab[5]  = '{-10000, 1, 0, -128, 1'b1};
    tab[6]  = '{12345, 0, 3, 0, 1'b0};
    tab[7]  = '{127, 1, 0, 127, 1'b0};
    tab[8]  = '{-128, 1, 0, -128, 1'b0};
    tab[9]  = '{-8388608, 255, 31, -1, 1'b0};
    tab[10] = '{4000, 255, 13, 125, 1'b0};

    clips[0] = '{-8388608, 255, 0, -128, 1'b1};
    clips[1] = '{200, 1, 0, 127, 1'b1};
    clips[2] = '{-129, 1, 0, -128, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    acc_in    = '0;
    mult_in   = '0;
    shift_in  = '0;
    idle(3);
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_q_out", q_out, 0);
    check("reset_sat_out", sat_out, 0);
    check("reset_sat_count", sat_count, 0);
    reset = 1'b0;
    idle(1);

    // Basic path and latency
    use_tab = 1'b1; tab_q = 100; tab_sat = 1'b0;
    send(100, 1, 0);
    latency(k);
    check("basic_latency", k, 3);
    idle(2);

    // Table vectors back to back
    for (int i = 0; i < 11; i++) begin
      tab_q   = tab[i].q;
      tab_sat = tab[i].sat;
      send(tab[i].acc, tab[i].mult, tab[i].shift);
    end
    idle(5);
    check("tab_sb_empty", sb.size(), 0);
    check("tab_sat_count", sat_count, 2);

    // Three more clips: 5 total, narrow counter pins at 3
    for (int i = 0; i < 3; i++) begin
      tab_q   = clips[i].q;
      tab_sat = clips[i].sat;
      send(clips[i].acc, clips[i].mult, clips[i].shift);
    end
    idle(5);
    check("clip_sat_count", sat_count, 5);
    check("clip_sat_count_w2", sat_count2, 3);

    // Backpressure mid-stream
    use_tab = 1'b0;
    o0 = n_out;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i, 1, 0);
      end
      begin
        idle(4);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    idle(6);
    check("bp_out_count", n_out - o0, 8);
    check("bp_sb_empty", sb.size(), 0);

    // Reset with three samples in flight
    out_ready = 1'b0;
    send(11, 1, 0);
    send(12, 1, 0);
    send(13, 1, 0);
    check("rst_pipe_full", out_valid, 1);
    reset = 1'b1;
    idle(1);
    reset     = 1'b0;
    out_ready = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sat_count", sat_count, 0);
    o0 = n_out;
    use_tab = 1'b1; tab_q = -7; tab_sat = 1'b0;
    send(-7, 1, 0);
    latency(k);
    check("rst_latency", k, 3);
    idle(3);
    check("rst_out_count", n_out - o0, 1);
    check("rst_sb_empty", sb.size(), 0);

    // Full-rate random stream
    use_tab = 1'b0;
    o0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 256; i++) begin
      a = int'($urandom_range(0, 32'hFF_FFFF)) - 8388608;
      if (i % 4 == 0) a = a / 4096;
      m = int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 31));
      send(a, m, s);
    end
    check("rand_cycles", cyc - c0, 256);
    idle(3);
    check("rand_out_count", n_out - o0, 256);
    check("rand_drained", out_valid, 0);
    check("rand_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/acc_requant_q35.md
Name: acc_requant_q35

Overview:
- Upstream feeder for the tanh activation stage.
- Takes signed MAC accumulator results from the PE array and requantizes each one into the Q3.5 signed 8-bit input format expected by the tanh unit (range −4 to +3.96875).
- Requantization is a fixed-point scale: multiply, round, arithmetic shift, saturate.
- Three-stage pipeline with a valid/ready handshake and a saturation event counter.

Parameters:
- ACC_W, 24, accumulator input width (signed).
- MULT_W, 8, scale multiplier width (unsigned).
- SHIFT_W, 5, right-shift amount width (shift 0..31).
- CNT_W, 16, saturation counter width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a sample.
- in_ready  output  1  block accepts the sample this cycle.
- acc_in  input  ACC_W  signed accumulator value.
- mult_in  input  MULT_W  unsigned scale, sampled with acc_in.
- shift_in  input  SHIFT_W  right-shift amount, sampled with acc_in.
- out_valid  output  1  q_out valid.
- out_ready  input  1  tanh stage accepts q_out.
- q_out  output  8  signed Q3.5 result.
- sat_out  output  1  this q_out was clipped.
- sat_count  output  CNT_W  number of clipped outputs since reset; sticks at all-ones.

Behaviour:
- Reset (reset=1 at a clock edge):
  - All stage valids, q_out, sat_out and sat_count go to 0 on that edge.
  - Reset applies mid-stream too: in-flight samples are discarded, never emitted.
  - in_ready is 0 while reset is high.
- Flow control:
  - advance = ~out_valid | out_ready; the whole pipeline moves only when advance=1.
  - in_ready = advance & ~reset (combinational).
  - Transfer in: in_valid & in_ready.
  - Transfer out: out_valid & out_ready.
  - Bubbles propagate as invalid stages; no skid buffer.
- Stage S1 (on transfer in):
  - prod = signed(acc_in) × zero-extended mult_in, width ACC_W+MULT_W (32).
  - shift_in is registered alongside prod.
- Stage S2:
  - If shift = 0: r = prod.
  - Else: r = (prod + (1 << (shift−1))) >>> shift, computed at ACC_W+MULT_W+1 bits so the rounding add cannot overflow.
  - This is round-half-up toward +inf: −1.5 → −1, +1.5 → +2.
- Stage S3:
  - r > 127 → q = 127, sat = 1.
  - r < −128 → q = −128, sat = 1.
  - Otherwise q = r[7:0], sat = 0.
  - Registered into q_out and sat_out.
- Latency:
  - 3 clk edges from input transfer to out_valid=1, with no stall.
  - Throughput is 1 sample per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, q_out, sat_out and all stage registers hold.
- sat_count:
  - Increments by 1 when the S3 register loads a valid sample with sat=1.
  - Saturates at 2^CNT_W−1; no wrap.
- Edge values:
  - mult_in=0 gives q=0, sat=0.
  - acc_in = most negative value with mult 255 and shift 0 saturates to −128.
  - Simultaneous in/out transfers are allowed every cycle.

Decomposition:
- Shared package act_pkg holds:
  - Q35_MIN = −128 and Q35_MAX = 127.
  - Q35_FRAC = 5.
  - The Q3.5 sample typedef (signed 8-bit), shared with the tanh stage.
- One natural sub-module: round_shift_sat.
  - Combinational round, shift and saturate.
  - Reused by other activation requantizers.
- Pipeline registers and handshake stay in the top level.

Test Plan:
- Basic path: acc=100, mult=1, shift=0, out_ready=1 → q_out=100, sat_out=0, out_valid exactly 3 cycles after accept.
- Scaling and rounding:
  - acc=64, mult=128, shift=8 → 32.
  - acc=3, mult=1, shift=1 → 2.
  - acc=−3, mult=1, shift=1 → −1.
  - acc=5, mult=3, shift=2 → 4 (15/4 = 3.75).
- Saturation:
  - acc=10000, mult=1, shift=0 → 127 with sat_out=1.
  - acc=−10000 → −128 with sat_out=1.
  - sat_count = 2 afterwards; with CNT_W=2 forced, 5 clip events → sat_count=3.
- Backpressure:
  - Stream acc=1..8 (mult=1, shift=0) with out_ready low for 5 cycles mid-stream.
  - All 8 values emerge in order with no loss or duplication.
  - q_out is stable during the stall; in_ready=0 while stalled.
- Reset mid-operation:
  - Assert reset for 1 cycle with 3 samples in flight → out_valid=0 and sat_count=0 next cycle.
  - No stale sample is emitted.
  - The next input emerges after 3 cycles.
- Back-to-back full rate: 256 random samples with out_ready=1 and in_valid=1 continuously → one output per cycle, matching a reference model of the round/shift/saturate arithmetic.
